// File: rtl/regm_wr_arbiter_if.sv
// Write-port bundle between the requesters and regm_wr_arbiter.
// master drives requests; slave is the arbiter side.
interface regm_wr_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        acc_valid;
    logic [4:0]  acc_reg;
    logic [31:0] acc_data;
    logic        acc_ready;
    logic        host_valid;
    logic [4:0]  host_reg;
    logic [31:0] host_data;
    logic        host_ready;
    logic        clear_start;
    logic        busy;
    logic        regwrite;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;
    logic [1:0]  grant_id;

    modport master (
        output wb_valid, wb_reg, wb_data,
        output acc_valid, acc_reg, acc_data,
        output host_valid, host_reg, host_data,
        output clear_start,
        input  wb_ready, acc_ready, host_ready,
        input  busy, regwrite, wrreg, wrdata, grant_id
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data,
        input  acc_valid, acc_reg, acc_data,
        input  host_valid, host_reg, host_data,
        input  clear_start,
        output wb_ready, acc_ready, host_ready,
        output busy, regwrite, wrreg, wrdata, grant_id
    );
endinterface

// File: rtl/regm_wr_arbiter.sv
// Shares the register-memory write port between writeback, accelerator
// and host, and zero-fills r1..r31 after reset or on request.
module regm_wr_arbiter #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int unsigned STARVE_LIMIT   = 8
) (
    input logic            clk,
    input logic            reset_n,
    regm_wr_arbiter_if.slave bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    localparam logic [1:0] GID_NONE = 2'd0;
    localparam logic [1:0] GID_WB   = 2'd1;
    localparam logic [1:0] GID_ACC  = 2'd2;
    localparam logic [1:0] GID_HOST = 2'd3;

    state_t      state, state_nx;
    logic [4:0]  clr_idx, clr_idx_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        force_slot, force_nx;
    logic        rr_host, rr_nx;
    logic        rw_q, rw_nx;
    logic [4:0]  reg_q, reg_nx;
    logic [31:0] dat_q, dat_nx;
    logic [1:0]  gid_q, gid_nx;

    logic run, in_clr, open, any_ah, pick_host;
    logic wb_gnt, acc_gnt, host_gnt, inc;

    assign run       = (state == RUN);
    assign in_clr    = (state == CLEAR);
    assign open      = run & ~bus.clear_start;
    assign any_ah    = bus.acc_valid | bus.host_valid;
    // rr_host set means host is favoured when both request
    assign pick_host = bus.host_valid & (~bus.acc_valid | rr_host);
    assign wb_gnt    = open & ~force_slot & bus.wb_valid;
    assign acc_gnt   = open & ~wb_gnt & bus.acc_valid & ~pick_host;
    assign host_gnt  = open & ~wb_gnt & pick_host;
    assign inc       = wb_gnt & any_ah;

    assign bus.wb_ready   = open & ~force_slot;
    assign bus.acc_ready  = acc_gnt;
    assign bus.host_ready = host_gnt;
    assign bus.busy       = in_clr;
    assign bus.regwrite   = rw_q;
    assign bus.wrreg      = reg_q;
    assign bus.wrdata     = dat_q;
    assign bus.grant_id   = gid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RST_STATE;
            clr_idx <= 5'd1;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        unique case (state)
            CLEAR: begin
                if (clr_idx == 5'd31) begin
                    state_nx   = RUN;
                    clr_idx_nx = 5'd1;
                end else begin
                    clr_idx_nx = clr_idx + 5'd1;
                end
            end
            RUN: begin
                if (bus.clear_start) begin
                    state_nx   = CLEAR;
                    clr_idx_nx = 5'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rw_nx  = 1'b0;
        reg_nx = reg_q;
        dat_nx = dat_q;
        gid_nx = GID_NONE;
        unique case (1'b1)
            in_clr: begin
                rw_nx  = 1'b1;
                reg_nx = clr_idx;
                dat_nx = '0;
            end
            wb_gnt: begin
                rw_nx  = (bus.wb_reg != 5'd0);
                reg_nx = bus.wb_reg;
                dat_nx = bus.wb_data;
                gid_nx = GID_WB;
            end
            acc_gnt: begin
                rw_nx  = (bus.acc_reg != 5'd0);
                reg_nx = bus.acc_reg;
                dat_nx = bus.acc_data;
                gid_nx = GID_ACC;
            end
            host_gnt: begin
                rw_nx  = (bus.host_reg != 5'd0);
                reg_nx = bus.host_reg;
                dat_nx = bus.host_data;
                gid_nx = GID_HOST;
            end
            default: ;
        endcase
    end

    // force_slot rises in the cycle the counter reaches the limit
    always_comb begin
        cnt_nx   = cnt;
        force_nx = 1'b0;
        rr_nx    = rr_host;
        if (!run || acc_gnt || host_gnt || !any_ah) begin
            cnt_nx = '0;
        end else if (inc) begin
            cnt_nx   = cnt + 8'd1;
            force_nx = ({1'b0, cnt} + 9'd1) == 9'(STARVE_LIMIT);
        end
        if (acc_gnt) rr_nx = 1'b1;
        if (host_gnt) rr_nx = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            force_slot <= 1'b0;
            rr_host    <= 1'b0;
            rw_q       <= 1'b0;
            reg_q      <= '0;
            dat_q      <= '0;
            gid_q      <= GID_NONE;
        end else begin
            cnt        <= cnt_nx;
            force_slot <= force_nx;
            rr_host    <= rr_nx;
            rw_q       <= rw_nx;
            reg_q      <= reg_nx;
            dat_q      <= dat_nx;
            gid_q      <= gid_nx;
        end
    end
endmodule

// File: tb/tb_regm_wr_arbiter.sv
// Directed bench for regm_wr_arbiter: vector table plus sequences
// for zero-fill, starvation and reset-during-clear.
module tb_regm_wr_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;

    regm_wr_arbiter_if bus ();

    regm_wr_arbiter #(
        .CLEAR_ON_RESET(1'b1),
        .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        hv;
        logic [4:0]  hr;
        logic [31:0] hd;
        logic [2:0]  rdy;
        logic        rw;
        logic [4:0]  rg;
        logic [31:0] dt;
        logic [1:0]  gid;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wv, input logic [4:0] wr,
                         input logic [31:0] wd, input logic av,
                         input logic [4:0] ar, input logic [31:0] ad,
                         input logic hv, input logic [4:0] hr,
                         input logic [31:0] hd, input logic cs);
        bus.wb_valid    = wv;
        bus.wb_reg      = wr;
        bus.wb_data     = wd;
        bus.acc_valid   = av;
        bus.acc_reg     = ar;
        bus.acc_data    = ad;
        bus.host_valid  = hv;
        bus.host_reg    = hr;
        bus.host_data   = hd;
        bus.clear_start = cs;
    endtask

    // rdy is {wb, acc, host}; outputs are checked one edge later
    task automatic step(input string tag, input logic [2:0] rdy,
                        input logic rw, input logic [4:0] rg,
                        input logic [31:0] dt, input logic [1:0] gid);
        @(negedge clk);
        chk({tag, "_ready"}, {29'd0, bus.wb_ready, bus.acc_ready,
                               bus.host_ready}, {29'd0, rdy});
        @(posedge clk);
        #1;
        chk({tag, "_regwrite"}, bus.regwrite, rw);
        chk({tag, "_grant_id"}, bus.grant_id, gid);
        if (rw) begin
            chk({tag, "_wrreg"}, bus.wrreg, rg);
            chk({tag, "_wrdata"}, bus.wrdata, dt);
        end
    endtask

    task automatic clear_walk(input int n, input int pulse_at);
        for (int k = 1; k <= n; k++) begin
            bus.clear_start = (k == pulse_at);
            @(negedge clk);
            chk("clr_ready", {bus.wb_ready, bus.acc_ready,
                              bus.host_ready}, 0);
            chk("clr_busy", bus.busy, 1);
            @(posedge clk);
            #1;
            chk("clr_regwrite", bus.regwrite, 1);
            chk("clr_wrreg", bus.wrreg, k);
            chk("clr_wrdata", bus.wrdata, 0);
            chk("clr_grant_id", bus.grant_id, 0);
            chk("clr_busy_after", bus.busy, (k != 31));
        end
        bus.clear_start = 1'b0;
    endtask

    function automatic vec_t mk(
        input logic wv, input logic [4:0] wr, input logic [31:0] wd,
        input logic av, input logic [4:0] ar, input logic [31:0] ad,
        input logic hv, input logic [4:0] hr, input logic [31:0] hd,
        input logic [2:0] rdy, input logic rw, input logic [4:0] rg,
        input logic [31:0] dt, input logic [1:0] gid);
        vec_t v;
        v.wv = wv; v.wr = wr; v.wd = wd;
        v.av = av; v.ar = ar; v.ad = ad;
        v.hv = hv; v.hr = hr; v.hd = hd;
        v.rdy = rdy; v.rw = rw; v.rg = rg; v.dt = dt; v.gid = gid;
        return v;
    endfunction

    initial begin
        vt[0]  = mk(1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,
                    3'b100, 1, 8, 32'hDEADBEEF, 1);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                    3'b100, 0, 0, 0, 0);
        vt[2]  = mk(0, 0, 0, 1, 3, 32'hA1, 1, 4, 32'hB1,
                    3'b110, 1, 3, 32'hA1, 2);
        vt[3]  = mk(0, 0, 0, 1, 5, 32'hA2, 1, 4, 32'hB1,
                    3'b101, 1, 4, 32'hB1, 3);
        vt[4]  = mk(0, 0, 0, 1, 5, 32'hA2, 1, 6, 32'hB2,
                    3'b110, 1, 5, 32'hA2, 2);
        vt[5]  = mk(0, 0, 0, 1, 7, 32'hA3, 1, 6, 32'hB2,
                    3'b101, 1, 6, 32'hB2, 3);
        vt[6]  = mk(0, 0, 0, 1, 7, 32'hA3, 0, 0, 0,
                    3'b110, 1, 7, 32'hA3, 2);
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h1234,
                    3'b101, 0, 0, 0, 3);
        vt[8]  = mk(1, 9, 32'h1, 1, 10, 32'h2, 0, 0, 0,
                    3'b100, 1, 9, 32'h1, 1);
        vt[9]  = mk(0, 0, 0, 1, 10, 32'h2, 0, 0, 0,
                    3'b110, 1, 10, 32'h2, 2);
        vt[10] = mk(1, 31, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0,
                    3'b100, 1, 31, 32'hFFFFFFFF, 1);
        vt[11] = mk(0, 0, 0, 1, 0, 32'h5, 0, 0, 0,
                    3'b110, 0, 0, 0, 2);
        vt[12] = mk(1, 0, 32'h9, 0, 0, 0, 0, 0, 0,
                    3'b100, 0, 0, 0, 1);

        drive(1, 5, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwrite", bus.regwrite, 0);
        chk("rst_wrreg", bus.wrreg, 0);
        chk("rst_wrdata", bus.wrdata, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_busy", bus.busy, 1);
        reset_n = 1'b1;
        clear_walk(31, 0);
        step("first_run_wb", 3'b100, 1, 5, 32'h55, 1);

        foreach (vt[i]) begin
            drive(vt[i].wv, vt[i].wr, vt[i].wd, vt[i].av, vt[i].ar,
                  vt[i].ad, vt[i].hv, vt[i].hr, vt[i].hd, 0);
            step($sformatf("vec%0d", i), vt[i].rdy, vt[i].rw,
                 vt[i].rg, vt[i].dt, vt[i].gid);
        end

        for (int j = 0; j < 27; j++) begin
            drive(1, 12, j, 1, 20, 32'hACC, 0, 0, 0, 0);
            if (j % 9 == 8)
                step($sformatf("starve%0d", j), 3'b010, 1, 20,
                     32'hACC, 2);
            else
                step($sformatf("starve%0d", j), 3'b100, 1, 12, j, 1);
        end

        drive(1, 2, 32'h7, 0, 0, 0, 0, 0, 0, 1);
        step("clear_start", 3'b000, 0, 0, 0, 0);
        chk("clear_start_busy", bus.busy, 1);
        clear_walk(31, 5);
        step("after_clear_wb", 3'b100, 1, 2, 32'h7, 1);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("clear_start2", 3'b000, 0, 0, 0, 0);
        bus.clear_start = 1'b0;
        clear_walk(16, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_regwrite", bus.regwrite, 0);
        chk("mid_rst_wrreg", bus.wrreg, 0);
        chk("mid_rst_wrdata", bus.wrdata, 0);
        chk("mid_rst_grant_id", bus.grant_id, 0);
        chk("mid_rst_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_walk(31, 0);
        drive(1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        step("final_wb", 3'b100, 1, 8, 32'hDEADBEEF, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("final_idle", 3'b100, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
